// File: rtl/cart_audio_pkg.sv
// Shared types, widths and helpers for the FM-PAC cartridge audio conditioning path.
package cart_audio_pkg;

  typedef enum logic [1:0] {
    S_ACC,
    S_CTR,
    S_DCB,
    S_OUT
  } fsm_t;

  localparam int ACC_W  = 21;
  localparam int FILT_W = 20;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767) begin
      return 16'sd32767;
    end else if (v < -24'sd32768) begin
      return -16'sd32768;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/cart_dc_blocker.sv
// First-order DC blocker: y <= x - x_prev + y - (y >>> DC_SHIFT), advanced once per enable.
module cart_dc_blocker
  import cart_audio_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [FILT_W-1:0] x_in,
  output logic signed [FILT_W-1:0] y_out
);

  logic signed [FILT_W-1:0] x_prev;
  logic signed [FILT_W-1:0] y_q;

  // y_q wraps at FILT_W bits; the output stage clamps downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev <= '0;
      y_q    <= '0;
    end else if (en) begin
      y_q    <= x_in - x_prev + y_q - (y_q >>> DC_SHIFT);
      x_prev <= x_in;
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/cart_fm_sound_conditioner.sv
// Decimates the multiplexed OPLL mix over one 72-slot frame, recentres, DC-blocks,
// then applies volume, mute and 16-bit saturation with a one-cycle valid strobe.
module cart_fm_sound_conditioner
  import cart_audio_pkg::*;
#(
  parameter int IN_W      = 14,
  parameter int OUT_W     = 16,
  parameter int DECIM     = 72,
  parameter int SUM_SHIFT = 6,
  parameter int DC_SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [IN_W-1:0]         sound_in,
  input  logic [3:0]              volume,
  input  logic                    mute,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid
);

  localparam int CNT_W  = $clog2(DECIM);
  localparam int OFFSET = (DECIM * (1 << (IN_W - 1))) >> SUM_SHIFT;

  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         sum_q;
  logic [ACC_W-1:0]         acc_next;
  logic [CNT_W-1:0]         cnt;
  logic                     win_end;
  logic signed [FILT_W-1:0] x_q;
  logic signed [FILT_W-1:0] y_q;
  logic signed [23:0]       prod;
  logic signed [23:0]       p;

  fsm_t state, state_nxt;
  logic ld_x, dcb_en, ld_out;

  assign acc_next = acc + ACC_W'(sound_in);
  assign win_end  = clk_en && (cnt == CNT_W'(DECIM - 1));

  // Accumulation free-runs; the FSM only post-processes the latched window sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      sum_q <= '0;
    end else if (win_end) begin
      sum_q <= acc_next;
      acc   <= '0;
      cnt   <= '0;
    end else if (clk_en) begin
      acc   <= acc_next;
      cnt   <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_x      = 1'b0;
    dcb_en    = 1'b0;
    ld_out    = 1'b0;
    case (state)
      S_ACC: if (win_end) state_nxt = S_CTR;
      S_CTR: begin
        ld_x      = 1'b1;
        state_nxt = S_DCB;
      end
      S_DCB: begin
        dcb_en    = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        ld_out    = 1'b1;
        state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
    end else if (ld_x) begin
      x_q <= FILT_W'(sum_q >> SUM_SHIFT) - FILT_W'(OFFSET);
    end
  end

  cart_dc_blocker #(
    .DC_SHIFT(DC_SHIFT)
  ) u_dc_blocker (
    .clk  (clk),
    .reset(reset),
    .en   (dcb_en),
    .x_in (x_q),
    .y_out(y_q)
  );

  assign prod = {{(24 - FILT_W){y_q[FILT_W-1]}}, y_q} * $signed({20'd0, volume});
  assign p    = prod >>> 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= ld_out;
      if (ld_out) begin
        sample_out <= mute ? '0 : OUT_W'(sat16(p));
      end
    end
  end

  window_overlap : assert property (@(posedge clk) disable iff (reset)
    !(win_end && state != S_ACC));

endmodule
